// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: latches one request, reads/merges/writes the word
// memory and returns extended load data. Optional MISALIGN_TRAP_EN traps misalignment.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [1:0]  lane_reg;
    logic [31:0] wdata_reg;
    logic        mis_reg;
    logic        resp_err_reg;

    logic        req_is_word;
    logic        req_is_half;
    logic        mis_req;
    logic [1:0]  eff_lane;
    logic [31:0] word_idx;
    logic        lat_is_word;
    logic        lat_is_half;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [3:0]  byte_sel;
    logic [31:0] wdata_rep;
    logic [31:0] merged;
    logic        unused_addr;

    assign req_is_word = req_size[1];
    assign req_is_half = (req_size == 2'b01);
    assign lat_is_word = size_reg[1];
    assign lat_is_half = (size_reg == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign mis_req = (req_is_half & req_addr[0]) | (req_is_word & (|req_addr[1:0]));
`else
    assign mis_req = 1'b0;
`endif

    // Low address bits that cannot select a lane of this size are dropped here.
    always_comb begin
        eff_lane = req_addr[1:0];
        if (req_is_word)
            eff_lane = 2'b00;
        else if (req_is_half)
            eff_lane = {req_addr[1], 1'b0};
    end

    assign word_idx    = {{(32 - ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
    assign unused_addr = ^{req_addr[31:ADDR_W+2]};

    assign shifted = mem_rdata >> {lane_reg, 3'b000};

    always_comb begin
        load_data = shifted;
        if (!lat_is_word) begin
            if (lat_is_half)
                load_data = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
            else
                load_data = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
        end
    end

    always_comb begin
        byte_sel  = 4'b1111;
        wdata_rep = wdata_reg;
        if (lat_is_half) begin
            byte_sel  = lane_reg[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_reg[15:0]}};
        end else if (!lat_is_word) begin
            byte_sel  = 4'b0001 << lane_reg;
            wdata_rep = {4{wdata_reg[7:0]}};
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = byte_sel[gi] ? wdata_rep[8*gi +: 8] : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            lane_reg     <= 2'b00;
            wdata_reg    <= 32'h0;
            mis_reg      <= 1'b0;
            req_ready    <= 1'b1;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wr_en    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        size_reg  <= req_size;
                        uns_reg   <= req_unsigned;
                        lane_reg  <= eff_lane;
                        wdata_reg <= req_wdata;
                        mis_reg   <= mis_req;
                        mem_addr  <= word_idx;
                        mem_wdata <= req_wdata;
                        // Word stores write during ACCESS, so the strobe is set on accept.
                        mem_wr_en <= req_we & req_is_word & ~mis_req;
                        req_ready <= 1'b0;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en    <= 1'b0;
                    resp_err_reg <= mis_reg;
                    if (mis_reg || (we_reg && lat_is_word)) begin
                        resp_rdata <= 32'h0;
                        resp_valid <= 1'b1;
                        state_reg  <= RESP;
                    end else if (!we_reg) begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state_reg  <= RESP;
                    end else begin
                        mem_wdata <= merged;
                        mem_wr_en <= 1'b1;
                        state_reg <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    mem_wr_en  <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_valid <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign resp_err = resp_err_reg;
`else
    logic unused_err;
    assign unused_err = resp_err_reg;
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, vector table and
// hand-written backpressure / mid-write reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Memory model: combinational read, posedge write, plus a clocked backdoor preload.
    logic [31:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [31:0] pre_val = 32'h0;
    int          wr_count = 0;
    logic [31:0] wr_addr = 32'h0;

    assign mem_rdata = mem[mem_addr[4:0]];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[4:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
            wr_addr  <= mem_addr;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_wr;
        logic        exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int          lat;
        int          wr_start;
        logic [4:0]  idx;
        logic [31:0] got;
        idx = vec[i].addr[6:2];
        preload(idx, vec[i].init);
        chk($sformatf("v%0d_req_ready_idle", i), {31'b0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = vec[i].we;
        req_size     = vec[i].size;
        req_unsigned = vec[i].uns;
        req_addr     = vec[i].addr;
        req_wdata    = vec[i].wdata;
        resp_ready   = 1'b1;
        @(posedge clk);
        wr_start = wr_count;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = resp_rdata;
        chk($sformatf("v%0d_latency", i), lat, vec[i].exp_lat);
        chk($sformatf("v%0d_rdata", i), got, vec[i].exp_rdata);
        chk($sformatf("v%0d_err", i), {31'b0, resp_err}, {31'b0, vec[i].exp_err});
        @(negedge clk);
        chk($sformatf("v%0d_req_ready_back", i), {31'b0, req_ready}, 32'h1);
        chk($sformatf("v%0d_write_pulses", i), wr_count - wr_start, vec[i].exp_wr);
        chk($sformatf("v%0d_mem_word", i), mem[idx], vec[i].exp_word);
        if (vec[i].exp_wr != 0)
            chk($sformatf("v%0d_wr_addr", i), wr_addr, {27'b0, idx});
        $display("vec %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d mem[%0d]=%h",
                 i, vec[i].we, vec[i].size, vec[i].uns, vec[i].addr, vec[i].wdata,
                 got, resp_err, lat, idx, mem[idx]);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;

        //        we    size   uns   addr        wdata         init          rdata         word        lat wr err
        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 2, 1, 1'b0};
        vec[1]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0, 1'b0};
        vec[2]  = '{1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFFA5, 32'h11223344, 32'h00000000, 32'h1122A544, 3, 1, 1'b0};
        vec[3]  = '{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'h1122A544, 32'hFFFFFFA5, 32'h1122A544, 2, 0, 1'b0};
        vec[4]  = '{1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'h1122A544, 32'h000000A5, 32'h1122A544, 2, 0, 1'b0};
        vec[5]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'h01234567, 32'h00000000, 32'hBEEF4567, 3, 1, 1'b0};
        vec[6]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h80007FFF, 32'h00007FFF, 32'h80007FFF, 2, 0, 1'b0};
        vec[7]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h80007FFF, 32'hFFFF8000, 32'h80007FFF, 2, 0, 1'b0};
        vec[8]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h80007FFF, 32'h00008000, 32'h80007FFF, 2, 0, 1'b0};
        vec[9]  = '{1'b0, 2'b00, 1'b0, 32'h17, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 32'h80FF0000, 2, 0, 1'b0};
        vec[10] = '{1'b0, 2'b11, 1'b0, 32'h1C, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2, 0, 1'b0};
        vec[11] = '{1'b1, 2'b10, 1'b0, 32'h84, 32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'h0F0F0F0F, 2, 1, 1'b0};
        vec[12] = '{1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF77, 3, 1, 1'b0};
`ifdef MISALIGN_TRAP_EN
        vec[13] = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        32'h80112233, 32'h00000000, 32'h80112233, 2, 0, 1'b1};
        vec[14] = '{1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 32'h55555555, 32'h00000000, 32'h55555555, 2, 0, 1'b1};
`else
        vec[13] = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        32'h80112233, 32'hFFFF8011, 32'h80112233, 2, 0, 1'b0};
        vec[14] = '{1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 32'h55555555, 32'h00000000, 32'h12345678, 2, 1, 1'b0};
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        reset = 1'b1;
        $display("reset released");

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: response must hold while resp_ready is low; new request ignored
        begin
            int lat;
            int wr_start;
            preload(5'd2, 32'h0BADF00D);
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
            req_addr = 32'h08; req_wdata = 32'h0; resp_ready = 1'b0;
            @(posedge clk);
            wr_start = wr_count;
            @(negedge clk);
            req_addr = 32'h0C; req_we = 1'b1;
            lat = 1;
            while (!resp_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("bp_latency", lat, 2);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk($sformatf("bp_hold_valid_%0d", c), {31'b0, resp_valid}, 32'h1);
                chk($sformatf("bp_hold_rdata_%0d", c), resp_rdata, 32'h0BADF00D);
                chk($sformatf("bp_req_ready_%0d", c), {31'b0, req_ready}, 32'h0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
            chk("bp_released_valid", {31'b0, resp_valid}, 32'h0);
            chk("bp_released_ready", {31'b0, req_ready}, 32'h1);
            chk("bp_no_write", wr_count - wr_start, 0);
            $display("backpressure load addr=08 rdata=0BADF00D held 5 cycles");
        end

        // Asynchronous reset while the merged word is being written
        begin
            int wr_start;
            preload(5'd8, 32'hAAAAAAAA);
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 32'h21; req_wdata = 32'h00000011; resp_ready = 1'b1;
            @(posedge clk);
            wr_start = wr_count;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            chk("mrst_wr_en_before", {31'b0, mem_wr_en}, 32'h1);
            chk("mrst_wdata_before", mem_wdata, 32'hAAAA11AA);
            reset = 1'b0;
            #1;
            chk("mrst_wr_en_dropped", {31'b0, mem_wr_en}, 32'h0);
            chk("mrst_req_ready", {31'b0, req_ready}, 32'h1);
            chk("mrst_resp_valid", {31'b0, resp_valid}, 32'h0);
            @(negedge clk);
            chk("mrst_word_unchanged", mem[8], 32'hAAAAAAAA);
            chk("mrst_no_write", wr_count - wr_start, 0);
            reset = 1'b1;
            $display("reset during merge write addr=21 mem[8]=%h", mem[8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
